// File: rtl/line_pixel_sampler_if.sv
// Sensor stream, control pulses and analyzer-facing results
// of the line pixel sampler, bundled for module ports.
interface line_pixel_sampler_if #(
    parameter int IW = 10
);
    logic          pixel_clock;
    logic [7:0]    data;
    logic          line_sync;
    logic          start;
    logic          stop;
    logic          enable;
    logic [IW-1:0] pixel_index;
    logic          pixel0_sample;
    logic          pixel1_sample;
    logic          pixel2_sample;
    logic [2:0]    sample_valid;
    logic [31:0]   line_counter;
    logic          frame_done;
    logic          overrun;

    modport master (
        output pixel_clock, data, line_sync, start, stop,
        input  enable, pixel_index, pixel0_sample, pixel1_sample,
        input  pixel2_sample, sample_valid, line_counter,
        input  frame_done, overrun
    );

    modport slave (
        input  pixel_clock, data, line_sync, start, stop,
        output enable, pixel_index, pixel0_sample, pixel1_sample,
        output pixel2_sample, sample_valid, line_counter,
        output frame_done, overrun
    );
endinterface

// File: rtl/line_pixel_sampler.sv
// Synchronises a linear sensor pixel stream, tracks the line
// position and thresholds three configured pixels per line.
module line_pixel_sampler #(
    parameter int LINE_LENGTH  = 1024,
    parameter int PIXEL0_INDEX = 15,
    parameter int PIXEL1_INDEX = 511,
    parameter int PIXEL2_INDEX = 1023,
    parameter int THRESHOLD    = 128
) (
    input  logic                 clock,
    input  logic                 resetn,
    line_pixel_sampler_if.slave  bus
);
    localparam int IW = $clog2(LINE_LENGTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_ACQ   = 2'd2;

    localparam logic [IW-1:0] P0   = IW'(PIXEL0_INDEX);
    localparam logic [IW-1:0] P1   = IW'(PIXEL1_INDEX);
    localparam logic [IW-1:0] P2   = IW'(PIXEL2_INDEX);
    localparam logic [IW-1:0] LAST = IW'(LINE_LENGTH - 1);
    localparam logic [7:0]    TH   = 8'(THRESHOLD);

    logic [2:0]    pclk_q;
    logic [7:0]    data_q [3];
    logic [2:0]    ls_q;
    logic          strobe_q;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   lc_q, lc_d;
    logic          ov_q, ov_d;
    logic [2:0]    samp_q, samp_d;
    logic [2:0]    sv_q, sv_d;
    logic          fd_q, fd_d;
    logic          take;
    logic          bit_v;

    // Bring pixel_clock, data and line_sync across with equal depth.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pclk_q    <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            data_q[2] <= '0;
            ls_q      <= '0;
            strobe_q  <= 1'b0;
        end else begin
            pclk_q    <= {pclk_q[1:0], bus.pixel_clock};
            data_q[0] <= bus.data;
            data_q[1] <= data_q[0];
            data_q[2] <= data_q[1];
            ls_q      <= {ls_q[1:0], bus.line_sync};
            strobe_q  <= pclk_q[1] & ~pclk_q[2];
        end
    end

    assign bit_v = (data_q[2] >= TH);

    // Acquisition state, line position and per-pixel sampling.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lc_d    = lc_q;
        ov_d    = ov_q;
        samp_d  = samp_q;
        sv_d    = '0;
        fd_d    = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_ARMED;
                    idx_d   = '0;
                    lc_d    = '0;
                    ov_d    = 1'b0;
                end
            end
            S_ARMED: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (strobe_q && ls_q[2]) begin
                    state_d = S_ACQ;
                    idx_d   = '0;
                    lc_d    = 32'd1;
                    take    = 1'b1;
                end
            end
            S_ACQ: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    fd_d    = 1'b1;
                end else if (strobe_q) begin
                    take = 1'b1;
                    if (ls_q[2]) begin
                        idx_d = '0;
                        if (lc_q != 32'hFFFF_FFFF)
                            lc_d = lc_q + 32'd1;
                    end else if (idx_q == LAST) begin
                        idx_d = '0;
                        ov_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            if (idx_d == P0) begin
                samp_d[0] = bit_v;
                sv_d[0]   = 1'b1;
            end
            if (idx_d == P1) begin
                samp_d[1] = bit_v;
                sv_d[1]   = 1'b1;
            end
            if (idx_d == P2) begin
                samp_d[2] = bit_v;
                sv_d[2]   = 1'b1;
            end
        end
    end

    // Register state and all analyzer-facing outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lc_q    <= '0;
            ov_q    <= 1'b0;
            samp_q  <= '0;
            sv_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lc_q    <= lc_d;
            ov_q    <= ov_d;
            samp_q  <= samp_d;
            sv_q    <= sv_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.enable        = (state_q == S_ACQ);
    assign bus.pixel_index   = idx_q;
    assign bus.pixel0_sample = samp_q[0];
    assign bus.pixel1_sample = samp_q[1];
    assign bus.pixel2_sample = samp_q[2];
    assign bus.sample_valid  = sv_q;
    assign bus.line_counter  = lc_q;
    assign bus.frame_done    = fd_q;
    assign bus.overrun       = ov_q;
endmodule

// File: tb/tb_line_pixel_sampler.sv
// Bench for line_pixel_sampler: scenario tasks checked
// against a line-position model of the sensor stream.
module tb_line_pixel_sampler;
    localparam int LL = 1024;
    localparam int P0 = 15;
    localparam int P1 = 511;
    localparam int P2 = 1023;
    localparam int TH = 128;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    line_pixel_sampler_if #(.IW(10)) bus ();

    line_pixel_sampler dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    int sv_seen = 0;
    int fd_seen = 0;
    always @(negedge clock) begin
        if (resetn) begin
            sv_seen += $countones(bus.sample_valid);
            fd_seen += int'(bus.frame_done);
        end
    end

    // model: 0 idle, 1 armed, 2 acquiring
    int          m_state = 0;
    int          m_idx = 0;
    int unsigned m_lc = 0;
    bit          m_ov = 0;
    bit [2:0]    m_samp = '0;
    int          m_sv = 0;

    task automatic model_pixel(input logic [7:0] d, input logic ls);
        bit took = 0;
        if (m_state == 1 && ls) begin
            m_state = 2;
            m_idx = 0;
            m_lc = 1;
            took = 1;
        end else if (m_state == 2) begin
            took = 1;
            if (ls) begin
                m_idx = 0;
                if (m_lc != 32'hFFFF_FFFF) m_lc++;
            end else if (m_idx == LL - 1) begin
                m_idx = 0;
                m_ov = 1;
            end else begin
                m_idx++;
            end
        end
        if (took) begin
            if (m_idx == P0) begin m_samp[0] = (d >= TH); m_sv++; end
            if (m_idx == P1) begin m_samp[1] = (d >= TH); m_sv++; end
            if (m_idx == P2) begin m_samp[2] = (d >= TH); m_sv++; end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ctrl(input logic s, input logic p);
        bus.start = s;
        bus.stop = p;
        @(negedge clock);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        @(negedge clock);
        if (p) m_state = 0;
        else if (s && m_state == 0) begin
            m_state = 1;
            m_lc = 0;
            m_ov = 0;
            m_idx = 0;
        end
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic ls);
        bus.data = d;
        bus.line_sync = ls;
        tick(4);
        bus.pixel_clock = 1'b1;
        tick(5);
        bus.pixel_clock = 1'b0;
        model_pixel(d, ls);
    endtask

    function automatic logic [7:0] plan_data(input int i);
        if (i == P0) return 8'd200;
        if (i == P1) return 8'd60;
        if (i == P2) return 8'd128;
        return 8'd0;
    endfunction

    task automatic test_reset;
        tick(3);
        checks++;
        if ({bus.enable, bus.pixel_index, bus.pixel0_sample,
             bus.pixel1_sample, bus.pixel2_sample, bus.sample_valid,
             bus.line_counter, bus.frame_done, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b idx=%0d lc=%0d ov=%b",
                     bus.enable, bus.pixel_index, bus.line_counter,
                     bus.overrun);
        end
        resetn = 1'b1;
        tick(2);
        send_pixel(8'd255, 1'b1);
        checks++;
        if (bus.enable !== 1'b0 || bus.pixel0_sample !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: en=%b exp 0", bus.enable);
        end
    endtask

    task automatic test_armed_ignore;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            send_pixel(8'($urandom_range(0, 255)), 1'b0);
        checks++;
        if (bus.enable !== 1'b0 || bus.pixel_index !== 10'd0
            || bus.line_counter !== 32'd0) begin
            errors++;
            $display("FAIL armed_nosync: en=%b idx=%0d lc=%0d exp 0 0 0",
                     bus.enable, bus.pixel_index, bus.line_counter);
        end
        bus.data = 8'd0;
        bus.line_sync = 1'b1;
        tick(4);
        bus.pixel_clock = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 3) begin
                checks++;
                if (bus.enable !== 1'b0) begin
                    errors++;
                    $display("FAIL enable_early: got %b exp 0", bus.enable);
                end
            end
            if (k == 4) begin
                checks++;
                if (bus.enable !== 1'b1 || bus.pixel_index !== 10'd0
                    || bus.line_counter !== 32'd1) begin
                    errors++;
                    $display("FAIL enable_rise: en=%b idx=%0d lc=%0d exp 1 0 1",
                             bus.enable, bus.pixel_index, bus.line_counter);
                end
            end
        end
        bus.pixel_clock = 1'b0;
        model_pixel(8'd0, 1'b1);
    endtask

    task automatic test_full_lines;
        int sv0 = sv_seen;
        int bad = 0;
        for (int i = 1; i < LL; i++) begin
            send_pixel(plan_data(i), 1'b0);
            checks++;
            if (bus.pixel_index !== 10'(m_idx)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL line1_idx: got %0d exp %0d",
                             bus.pixel_index, m_idx);
            end
        end
        for (int i = 0; i < LL; i++) begin
            send_pixel(plan_data(i), i == 0);
            checks++;
            if (bus.pixel_index !== 10'(m_idx)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL line2_idx: got %0d exp %0d",
                             bus.pixel_index, m_idx);
            end
        end
        checks++;
        if ({bus.pixel0_sample, bus.pixel1_sample, bus.pixel2_sample}
            !== 3'b101) begin
            errors++;
            $display("FAIL line_samples: got %b%b%b exp 101",
                     bus.pixel0_sample, bus.pixel1_sample, bus.pixel2_sample);
        end
        checks++;
        if (sv_seen - sv0 != 6) begin
            errors++;
            $display("FAIL valid_pulses: got %0d exp 6", sv_seen - sv0);
        end
        checks++;
        if (bus.line_counter !== 32'd2 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL line_count: lc=%0d ov=%b exp 2 0",
                     bus.line_counter, bus.overrun);
        end
    endtask

    task automatic test_overrun;
        int bad = 0;
        logic [7:0] d;
        ctrl(1'b0, 1'b1);
        ctrl(1'b1, 1'b0);
        checks++;
        if (bus.line_counter !== 32'd0 || bus.pixel_index !== 10'd0) begin
            errors++;
            $display("FAIL start_clear: lc=%0d idx=%0d exp 0 0",
                     bus.line_counter, bus.pixel_index);
        end
        for (int i = 0; i < 1030; i++) begin
            d = 8'($urandom_range(0, 255));
            send_pixel(d, i == 0);
            checks++;
            if (bus.pixel_index !== 10'(m_idx) || bus.overrun !== m_ov) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL ovr_step %0d: idx=%0d ov=%b exp %0d %b", i,
                             bus.pixel_index, bus.overrun, m_idx, m_ov);
            end
            if (i == LL) begin
                checks++;
                if (bus.pixel_index !== 10'd0) begin
                    errors++;
                    $display("FAIL wrap_idx: got %0d exp 0", bus.pixel_index);
                end
            end
        end
        checks++;
        if (bus.overrun !== 1'b1 || bus.line_counter !== 32'd1) begin
            errors++;
            $display("FAIL overrun_end: ov=%b lc=%0d exp 1 1",
                     bus.overrun, bus.line_counter);
        end
        checks++;
        if ({bus.pixel2_sample, bus.pixel1_sample, bus.pixel0_sample}
            !== m_samp) begin
            errors++;
            $display("FAIL rand_samples: got %b%b%b exp %b",
                     bus.pixel2_sample, bus.pixel1_sample,
                     bus.pixel0_sample, m_samp);
        end
    endtask

    task automatic test_stop_strobe;
        int fd0;
        logic old0;
        for (int i = 0; i < P0; i++)
            send_pixel(8'($urandom_range(0, 255)), i == 0);
        old0 = bus.pixel0_sample;
        fd0 = fd_seen;
        bus.data = old0 ? 8'd0 : 8'd255;
        bus.line_sync = 1'b0;
        tick(4);
        bus.pixel_clock = 1'b1;
        tick(3);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        checks++;
        if (bus.enable !== 1'b0 || bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL stop_edge: en=%b fd=%b exp 0 1",
                     bus.enable, bus.frame_done);
        end
        tick(1);
        bus.pixel_clock = 1'b0;
        m_state = 0;
        tick(4);
        checks++;
        if (bus.pixel0_sample !== old0 || bus.pixel_index !== 10'd14) begin
            errors++;
            $display("FAIL stop_discard: s0=%b idx=%0d exp %b 14",
                     bus.pixel0_sample, bus.pixel_index, old0);
        end
        checks++;
        if (fd_seen - fd0 != 1) begin
            errors++;
            $display("FAIL frame_done_cnt: got %0d exp 1", fd_seen - fd0);
        end
    endtask

    task automatic test_start_stop_idle;
        ctrl(1'b1, 1'b1);
        send_pixel(8'd255, 1'b1);
        checks++;
        if (bus.enable !== 1'b0 || bus.line_counter !== 32'd2
            || bus.overrun !== 1'b1 || bus.pixel_index !== 10'd14) begin
            errors++;
            $display("FAIL start_stop: en=%b lc=%0d ov=%b idx=%0d exp 0 2 1 14",
                     bus.enable, bus.line_counter, bus.overrun,
                     bus.pixel_index);
        end
        ctrl(1'b1, 1'b0);
        checks++;
        if (bus.line_counter !== 32'd0 || bus.overrun !== 1'b0
            || bus.pixel_index !== 10'd0 || bus.enable !== 1'b0) begin
            errors++;
            $display("FAIL late_start: lc=%0d ov=%b idx=%0d en=%b exp 0 0 0 0",
                     bus.line_counter, bus.overrun, bus.pixel_index,
                     bus.enable);
        end
    endtask

    task automatic test_reset_midline;
        for (int i = 0; i <= 300; i++)
            send_pixel(8'($urandom_range(0, 255)), i == 0);
        checks++;
        if (bus.pixel_index !== 10'd300 || bus.enable !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: idx=%0d en=%b exp 300 1",
                     bus.pixel_index, bus.enable);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.enable, bus.pixel_index, bus.pixel0_sample,
             bus.pixel1_sample, bus.pixel2_sample, bus.sample_valid,
             bus.line_counter, bus.frame_done, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL async_reset: en=%b idx=%0d lc=%0d s=%b%b%b",
                     bus.enable, bus.pixel_index, bus.line_counter,
                     bus.pixel0_sample, bus.pixel1_sample, bus.pixel2_sample);
        end
        m_state = 0; m_idx = 0; m_lc = 0; m_ov = 0; m_samp = '0;
        tick(2);
        resetn = 1'b1;
        tick(2);
        send_pixel(8'd255, 1'b1);
        send_pixel(8'd255, 1'b0);
        checks++;
        if (bus.enable !== 1'b0 || bus.pixel_index !== 10'd0
            || bus.line_counter !== 32'd0) begin
            errors++;
            $display("FAIL post_reset: en=%b idx=%0d lc=%0d exp 0 0 0",
                     bus.enable, bus.pixel_index, bus.line_counter);
        end
        ctrl(1'b1, 1'b0);
        send_pixel(8'd9, 1'b1);
        checks++;
        if (bus.enable !== 1'b1 || bus.line_counter !== 32'(m_lc)) begin
            errors++;
            $display("FAIL restart: en=%b lc=%0d exp 1 %0d",
                     bus.enable, bus.line_counter, m_lc);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.pixel_clock = 1'b0;
        bus.data = 8'd0;
        bus.line_sync = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        test_reset();
        test_armed_ignore();
        test_full_lines();
        test_overrun();
        test_stop_strobe();
        test_start_stop_idle();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
